// File: rtl/sysbus_arb_pkg.sv
// Shared types and defaults for the Sysbus I/D arbiter.
package sysbus_arb_pkg;

    // Bus geometry shared with the I and D caches.
    localparam int SYSBUS_DW     = 64;
    localparam int SYSBUS_TW     = 13;
    localparam int SYSBUS_BEATS  = 8;

    // Tag MSB set marks a write request.
    localparam int WRITE_TAG_BIT = SYSBUS_TW - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

endpackage

// File: rtl/sysbus_arbiter_rr_pick2.sv
// Two-way round-robin chooser: a lone bidder wins, a tie goes to the one that did not own last.
module rr_pick2
    import sysbus_arb_pkg::*;
(
    input  logic   i_bid_i,
    input  logic   i_bid_d,
    input  owner_t i_last,
    output owner_t o_winner
);

    // Pick the winner from the current bids and the previous owner.
    always_comb begin
        o_winner = OWN_NONE;
        if (i_bid_i && i_bid_d) begin
            o_winner = (i_last == OWN_I) ? OWN_D : OWN_I;
        end else if (i_bid_i) begin
            o_winner = OWN_I;
        end else if (i_bid_d) begin
            o_winner = OWN_D;
        end
    end

endmodule

// File: rtl/sysbus_arbiter.sv
// Shares the Sysbus master port between I-cache and D-cache, one whole transaction per grant.
//
// Handshake: a request beat transfers when bus_reqcyc & bus_reqack are both high at a clock edge;
// a response beat transfers when bus_respcyc & bus_respack are both high at a clock edge.
module sysbus_arbiter
    import sysbus_arb_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = SYSBUS_DW,
    parameter int BUS_TAG_WIDTH  = SYSBUS_TW,
    parameter int BEATS          = SYSBUS_BEATS
) (
    input  logic                      clk,
    input  logic                      reset,
    // I-cache side
    input  logic                      i_bid,
    input  logic                      i_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] i_req,
    input  logic [BUS_TAG_WIDTH-1:0]  i_reqtag,
    input  logic                      i_respack,
    output logic                      i_grant,
    output logic                      i_reqack,
    output logic                      i_respcyc,
    // D-cache side
    input  logic                      d_bid,
    input  logic                      d_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] d_req,
    input  logic [BUS_TAG_WIDTH-1:0]  d_reqtag,
    input  logic                      d_respack,
    output logic                      d_grant,
    output logic                      d_reqack,
    output logic                      d_respcyc,
    // Bus side
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_respack,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    // Debug visibility of the FSM
    output state_t                    o_dbg_state,
    output owner_t                    o_dbg_last
);

    localparam int CW = $clog2(BEATS + 2);
    // Counter value on the final write beat (1 address beat + BEATS data beats).
    localparam logic [CW-1:0] WR_LAST = CW'(BEATS);
    // Counter value on the final response beat.
    localparam logic [CW-1:0] RD_LAST = CW'(BEATS - 1);

    state_t          r_state, w_state_nxt;
    owner_t          r_owner, w_owner_nxt;
    owner_t          r_last,  w_last_nxt;
    owner_t          w_winner;
    logic [CW-1:0]   r_cnt,   w_cnt_nxt;
    logic            r_is_write, w_is_write_nxt;

    logic            w_own_i, w_own_d, w_in_req, w_in_resp;
    logic            w_own_bid, w_req_beat, w_resp_beat, w_beat_write;

    rr_pick2 u_pick (
        .i_bid_i  (i_bid),
        .i_bid_d  (d_bid),
        .i_last   (r_last),
        .o_winner (w_winner)
    );

    assign w_own_i   = (r_owner == OWN_I);
    assign w_own_d   = (r_owner == OWN_D);
    assign w_in_req  = (r_state == REQ);
    assign w_in_resp = (r_state == RESP);

    assign i_grant   = w_own_i;
    assign d_grant   = w_own_d;
    assign i_reqack  = w_own_i & w_in_req  & bus_reqack;
    assign d_reqack  = w_own_d & w_in_req  & bus_reqack;
    assign i_respcyc = w_own_i & w_in_resp & bus_respcyc;
    assign d_respcyc = w_own_d & w_in_resp & bus_respcyc;

    assign o_dbg_state = r_state;
    assign o_dbg_last  = r_last;

    // Route the owner's request lines to the bus during REQ and its respack during RESP.
    always_comb begin
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;
        w_own_bid   = 1'b0;
        if (w_own_i) begin
            w_own_bid = i_bid;
            if (w_in_req) begin
                bus_reqcyc = i_reqcyc;
                bus_req    = i_req;
                bus_reqtag = i_reqtag;
            end
            bus_respack = w_in_resp & i_respack;
        end else if (w_own_d) begin
            w_own_bid = d_bid;
            if (w_in_req) begin
                bus_reqcyc = d_reqcyc;
                bus_req    = d_req;
                bus_reqtag = d_reqtag;
            end
            bus_respack = w_in_resp & d_respack;
        end
    end

    assign w_req_beat  = bus_reqcyc  & bus_reqack;
    assign w_resp_beat = bus_respcyc & bus_respack;

    // Next-state logic: grant in IDLE, count request beats in REQ, count response beats in RESP.
    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_last_nxt     = r_last;
        w_cnt_nxt      = r_cnt;
        w_is_write_nxt = r_is_write;
        w_beat_write   = r_is_write;
        case (r_state)
            IDLE: begin
                w_cnt_nxt      = '0;
                w_is_write_nxt = 1'b0;
                if (w_winner != OWN_NONE) begin
                    w_state_nxt = REQ;
                    w_owner_nxt = w_winner;
                end
            end
            REQ: begin
                if (w_req_beat) begin
                    // The write/read decision is taken from the first acked beat only.
                    if (r_cnt == '0) begin
                        w_beat_write = bus_reqtag[BUS_TAG_WIDTH-1];
                    end
                    w_is_write_nxt = w_beat_write;
                    if (!w_beat_write) begin
                        w_state_nxt = RESP;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == WR_LAST) begin
                        w_state_nxt = IDLE;
                        w_owner_nxt = OWN_NONE;
                        w_last_nxt  = r_owner;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end else if ((r_cnt == '0) && !w_own_bid) begin
                    // Owner gave up before anything was accepted.
                    w_state_nxt = IDLE;
                    w_owner_nxt = OWN_NONE;
                    w_last_nxt  = r_owner;
                    w_cnt_nxt   = '0;
                end
            end
            RESP: begin
                if (w_resp_beat) begin
                    if (r_cnt == RD_LAST) begin
                        w_state_nxt = IDLE;
                        w_owner_nxt = OWN_NONE;
                        w_last_nxt  = r_owner;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_owner_nxt = OWN_NONE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State registers with synchronous reset; I wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_owner    <= OWN_NONE;
            r_last     <= OWN_D;
            r_cnt      <= '0;
            r_is_write <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_last     <= w_last_nxt;
            r_cnt      <= w_cnt_nxt;
            r_is_write <= w_is_write_nxt;
        end
    end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter: read, tie-break, write, stall, abandon and mid-burst reset.
module tb_sysbus_arbiter;
    import sysbus_arb_pkg::*;

    localparam int DW = SYSBUS_DW;
    localparam int TW = SYSBUS_TW;
    localparam int NB = SYSBUS_BEATS;

    logic          clk;
    logic          reset;
    logic          i_bid, i_reqcyc, i_respack;
    logic [DW-1:0] i_req;
    logic [TW-1:0] i_reqtag;
    logic          i_grant, i_reqack, i_respcyc;
    logic          d_bid, d_reqcyc, d_respack;
    logic [DW-1:0] d_req;
    logic [TW-1:0] d_reqtag;
    logic          d_grant, d_reqack, d_respcyc;
    logic          bus_reqcyc, bus_respack, bus_reqack, bus_respcyc;
    logic [DW-1:0] bus_req;
    logic [TW-1:0] bus_reqtag;
    state_t        dbg_state;
    owner_t        dbg_last;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [TW-1:0] wtag;

    sysbus_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .i_bid       (i_bid),
        .i_reqcyc    (i_reqcyc),
        .i_req       (i_req),
        .i_reqtag    (i_reqtag),
        .i_respack   (i_respack),
        .i_grant     (i_grant),
        .i_reqack    (i_reqack),
        .i_respcyc   (i_respcyc),
        .d_bid       (d_bid),
        .d_reqcyc    (d_reqcyc),
        .d_req       (d_req),
        .d_reqtag    (d_reqtag),
        .d_respack   (d_respack),
        .d_grant     (d_grant),
        .d_reqack    (d_reqack),
        .d_respcyc   (d_respcyc),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_respack (bus_respack),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .o_dbg_state (dbg_state),
        .o_dbg_last  (dbg_last)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        i_bid = 0; i_reqcyc = 0; i_req = '0; i_reqtag = '0; i_respack = 0;
        d_bid = 0; d_reqcyc = 0; d_req = '0; d_reqtag = '0; d_respack = 0;
        bus_reqack = 0; bus_respcyc = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Scoreboard comparison
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        clear_inputs();
        do_reset();

        // Reset state
        check("rst_igrant", i_grant, 0);
        check("rst_dgrant", d_grant, 0);
        check("rst_state", dbg_state, IDLE);
        check("rst_last", dbg_last, OWN_D);
        check("rst_reqcyc", bus_reqcyc, 0);
        check("rst_req", bus_req, 0);
        check("rst_respack", bus_respack, 0);

        // 1: I-cache read
        i_bid = 1; i_reqcyc = 1; i_req = 64'h1000; i_reqtag = 13'h0021;
        step();
        check("t1_igrant", i_grant, 1);
        check("t1_dgrant", d_grant, 0);
        check("t1_state", dbg_state, REQ);
        check("t1_reqcyc", bus_reqcyc, 1);
        check("t1_req", bus_req, 64'h1000);
        check("t1_reqtag", bus_reqtag, 13'h0021);
        check("t1_noack", i_reqack, 0);
        bus_reqack = 1;
        settle();
        check("t1_ireqack", i_reqack, 1);
        check("t1_dreqack", d_reqack, 0);
        step();
        check("t1_resp", dbg_state, RESP);
        bus_reqack = 0; i_reqcyc = 0; i_bid = 0;
        bus_respcyc = 1; i_respack = 1;
        settle();
        check("t1_reqcyc_off", bus_reqcyc, 0);
        check("t1_hold", i_grant, 1);
        for (int k = 0; k < NB; k++) begin
            check("t1_rstate", dbg_state, RESP);
            check("t1_irespcyc", i_respcyc, 1);
            check("t1_respack", bus_respack, 1);
            step();
        end
        bus_respcyc = 0; i_respack = 0;
        settle();
        check("t1_idle", dbg_state, IDLE);
        check("t1_igrant_off", i_grant, 0);
        check("t1_last", dbg_last, OWN_I);

        // 2: both bid from reset, I first, then D after one IDLE cycle
        do_reset();
        i_bid = 1; d_bid = 1; i_reqcyc = 1; d_reqcyc = 1;
        i_req = 64'hA; d_req = 64'hB; i_reqtag = '0;
        step();
        check("t2_igrant", i_grant, 1);
        check("t2_dgrant", d_grant, 0);
        check("t2_req", bus_req, 64'hA);
        bus_reqack = 1;
        settle();
        check("t2_dreqack", d_reqack, 0);
        step();
        bus_reqack = 0; i_bid = 0; i_reqcyc = 0;
        bus_respcyc = 1; i_respack = 1; d_respack = 1;
        settle();
        for (int k = 0; k < NB; k++) begin
            check("t2_rstate", dbg_state, RESP);
            check("t2_drespcyc", d_respcyc, 0);
            step();
        end
        bus_respcyc = 0; i_respack = 0; d_respack = 0;
        wtag = '0;
        wtag[WRITE_TAG_BIT] = 1'b1;
        wtag[3:0] = 4'h5;
        d_reqtag = wtag; d_req = 64'hD000;
        settle();
        check("t2_gap_state", dbg_state, IDLE);
        check("t2_gap_dgrant", d_grant, 0);
        step();
        check("t2_dgrant", d_grant, 1);
        check("t2_dstate", dbg_state, REQ);

        // 3: D write, 9 acked beats, stray bus_respcyc never forwarded
        for (int k = 0; k <= NB; k++) exp_q.push_back(64'hD000 + 64'(k));
        bus_reqack = 1; bus_respcyc = 1;
        for (int k = 0; k <= NB; k++) begin
            d_req = 64'hD000 + 64'(k);
            settle();
            check("t3_state", dbg_state, REQ);
            check("t3_req", bus_req, exp_q.pop_front());
            check("t3_dreqack", d_reqack, 1);
            check("t3_drespcyc", d_respcyc, 0);
            check("t3_respack", bus_respack, 0);
            step();
            if (k == 0) begin
                d_bid = 0;
                d_reqtag = '0;
            end
        end
        bus_reqack = 0; bus_respcyc = 0; d_reqcyc = 0;
        settle();
        check("t3_idle", dbg_state, IDLE);
        check("t3_dgrant_off", d_grant, 0);
        check("t3_last", dbg_last, OWN_D);

        // 4: response stall holds the beat counter
        i_bid = 1; i_reqcyc = 1; i_reqtag = '0; i_req = 64'h2000;
        step();
        check("t4_igrant", i_grant, 1);
        bus_reqack = 1;
        step();
        bus_reqack = 0; i_bid = 0; i_reqcyc = 0;
        bus_respcyc = 1; i_respack = 1;
        for (int k = 0; k < 3; k++) step();
        i_respack = 0;
        settle();
        for (int k = 0; k < 3; k++) begin
            check("t4_stall_respack", bus_respack, 0);
            check("t4_stall_irespcyc", i_respcyc, 1);
            check("t4_stall_state", dbg_state, RESP);
            step();
        end
        i_respack = 1;
        settle();
        for (int k = 0; k < NB - 3; k++) begin
            check("t4_rstate", dbg_state, RESP);
            step();
        end
        bus_respcyc = 0; i_respack = 0;
        settle();
        check("t4_idle", dbg_state, IDLE);
        check("t4_last", dbg_last, OWN_I);

        // 5: D abandons before any ack, pending I bid granted
        d_bid = 1; d_reqcyc = 1; d_reqtag = '0; d_req = 64'h3000;
        step();
        check("t5_dgrant", d_grant, 1);
        d_bid = 0; i_bid = 1; i_reqcyc = 1;
        settle();
        check("t5_req", bus_req, 64'h3000);
        step();
        check("t5_idle", dbg_state, IDLE);
        check("t5_dgrant_off", d_grant, 0);
        check("t5_igrant_off", i_grant, 0);
        check("t5_last", dbg_last, OWN_D);
        d_reqcyc = 0;
        step();
        check("t5_igrant", i_grant, 1);
        check("t5_state", dbg_state, REQ);
        i_bid = 0;
        step();
        check("t5_abandon", dbg_state, IDLE);
        check("t5_last2", dbg_last, OWN_I);

        // 6: reset in the middle of a response burst
        i_bid = 1; i_reqcyc = 1; i_reqtag = '0;
        step();
        bus_reqack = 1;
        step();
        bus_reqack = 0; i_reqcyc = 0;
        bus_respcyc = 1; i_respack = 1;
        for (int k = 0; k < 4; k++) step();
        check("t6_mid", dbg_state, RESP);
        reset = 1; d_bid = 1; i_reqcyc = 1; d_reqcyc = 1;
        step();
        check("t6_igrant", i_grant, 0);
        check("t6_dgrant", d_grant, 0);
        check("t6_irespcyc", i_respcyc, 0);
        check("t6_respack", bus_respack, 0);
        check("t6_reqcyc", bus_reqcyc, 0);
        check("t6_state", dbg_state, IDLE);
        check("t6_last", dbg_last, OWN_D);
        reset = 0; bus_respcyc = 0;
        step();
        check("t6_regrant", i_grant, 1);
        check("t6_dwait", d_grant, 0);
        check("t6_reqcyc_on", bus_reqcyc, 1);
        clear_inputs();
        step();
        check("t6_done", dbg_state, IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
